// File: rtl/rf_wr_arbiter_pkg.sv
// rf_wr_arbiter_pkg: shared widths, write bundle and grant-source types
package rf_wr_arbiter_pkg;
  localparam int REG_W = 5;
  localparam int XLEN = 32;
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0] dat;
  } rf_wr_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_WB, GNT_BUF, GNT_BYP} gnt_t;
endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: in-order result buffer with squash-by-rd compaction and rd-match queries
module rf_wr_fifo
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  rf_wr_t           enq_ent,
  input  logic             deq,
  input  logic             sq,
  input  logic [REG_W-1:0] sq_rd,
  input  logic [REG_W-1:0] q1,
  input  logic [REG_W-1:0] q2,
  output rf_wr_t           head,
  output logic             empty,
  output logic             full,
  output logic             hit1,
  output logic             hit2
);
  logic [DEPTH-1:0] vld, n_vld, keep;
  rf_wr_t ent [DEPTH];
  rf_wr_t n_ent [DEPTH];
  int cnt;
  assign head = ent[0];
  assign empty = !vld[0];
  assign full = vld[DEPTH-1];
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = vld[i] && !(deq && i == 0) && !(sq && ent[i].rd == sq_rd);
      hit1 = hit1 || (vld[i] && ent[i].rd == q1);
      hit2 = hit2 || (vld[i] && ent[i].rd == q2);
    end
  end
  // survivors slide down to the lowest free slots, new entry lands right after them
  always_comb begin
    n_vld = '0;
    cnt = 0;
    for (int k = 0; k < DEPTH; k++) n_ent[k] = ent[k];
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (k == cnt) begin
            n_vld[k] = 1'b1;
            n_ent[k] = ent[i];
          end
        end
        cnt = cnt + 1;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (enq && k == cnt) begin
        n_vld[k] = 1'b1;
        n_ent[k] = enq_ent;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) vld <= '0;
    else begin
      vld <= n_vld;
      ent <= n_ent;
    end
  end
endmodule

// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register-file write port between writeback and a buffered multi-cycle unit
module rf_wr_arbiter #(
  parameter int XLEN = rf_wr_arbiter_pkg::XLEN,
  parameter int DEPTH = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wb_vld,
  input  logic [rf_wr_arbiter_pkg::REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]                   wb_dat,
  output logic                              wb_stall,
  input  logic                              mc_vld,
  input  logic [rf_wr_arbiter_pkg::REG_W-1:0] mc_rd,
  input  logic [XLEN-1:0]                   mc_dat,
  output logic                              mc_rdy,
  input  logic [rf_wr_arbiter_pkg::REG_W-1:0] qry_rs1,
  input  logic [rf_wr_arbiter_pkg::REG_W-1:0] qry_rs2,
  output logic                              qry_hit,
  output logic                              rf_we,
  output logic [rf_wr_arbiter_pkg::REG_W-1:0] rf_rd,
  output logic [XLEN-1:0]                   rf_dat
);
  import rf_wr_arbiter_pkg::*;
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic full, empty, hit1, hit2, acc, frc, sq, enq, deq, head_sq;
  logic [WW-1:0] wait_cnt;
  rf_wr_t wb, mc, head, sel, rf;
  gnt_t gnt;
  assign wb = '{rd: wb_rd, dat: wb_dat};
  assign mc = '{rd: mc_rd, dat: mc_dat};
  assign mc_rdy = !rst && !full;
  assign acc = mc_vld && mc_rdy;
  assign frc = !empty && (full || wait_cnt >= WW'(MAX_WAIT));
  assign gnt = frc ? GNT_BUF : wb_vld ? GNT_WB : !empty ? GNT_BUF : acc ? GNT_BYP : GNT_NONE;
  assign wb_stall = !rst && wb_vld && gnt != GNT_WB;
  // a granted writeback is younger than any buffered result to the same rd
  assign sq = gnt == GNT_WB && wb_rd != '0;
  assign enq = acc && gnt != GNT_BYP && mc_rd != '0 && !(sq && mc_rd == wb_rd);
  assign deq = gnt == GNT_BUF;
  assign head_sq = sq && !empty && head.rd == wb_rd;
  assign sel = gnt == GNT_BUF ? head : gnt == GNT_WB ? wb : gnt == GNT_BYP ? mc : '0;
  assign qry_hit = !rst && ((qry_rs1 != '0 && (hit1 || (rf_we && rf.rd == qry_rs1))) ||
                            (qry_rs2 != '0 && (hit2 || (rf_we && rf.rd == qry_rs2))));
  assign rf_rd = rf.rd;
  assign rf_dat = rf.dat;
  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .enq(enq), .enq_ent(mc), .deq(deq), .sq(sq), .sq_rd(wb_rd),
    .q1(qry_rs1), .q2(qry_rs2), .head(head), .empty(empty), .full(full), .hit1(hit1), .hit2(hit2)
  );
  // a result enqueued into an empty buffer was already denied once
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf <= '0;
      wait_cnt <= '0;
    end else begin
      rf_we <= gnt != GNT_NONE && sel.rd != '0;
      rf <= sel;
      wait_cnt <= (deq || head_sq || (empty && !enq)) ? '0 :
                  wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed vectors for the register-file write arbiter
module tb_rf_wr_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic wb_vld = 1'b0, mc_vld = 1'b0;
  logic [4:0] wb_rd = '0, mc_rd = '0, qry_rs1 = '0, qry_rs2 = '0;
  logic [31:0] wb_dat = '0, mc_dat = '0;
  logic wb_stall, mc_rdy, qry_hit, rf_we;
  logic [4:0] rf_rd;
  logic [31:0] rf_dat;
  int nvec = 0, nerr = 0;
  logic [6:0] f_wv = 7'b0111111;
  logic [6:0] f_mv = 7'b0001111;
  logic [6:0] f_rdy = 7'b1101011;
  logic [6:0] f_stall = 7'b0010100;
  logic [4:0] f_mr [7] = '{5'd10, 5'd11, 5'd12, 5'd12, 5'd0, 5'd0, 5'd0};
  logic [4:0] f_er [7] = '{5'd3, 5'd3, 5'd10, 5'd3, 5'd11, 5'd3, 5'd12};

  rf_wr_arbiter dut (
    .clk(clk), .rst(rst), .wb_vld(wb_vld), .wb_rd(wb_rd), .wb_dat(wb_dat), .wb_stall(wb_stall),
    .mc_vld(mc_vld), .mc_rd(mc_rd), .mc_dat(mc_dat), .mc_rdy(mc_rdy),
    .qry_rs1(qry_rs1), .qry_rs2(qry_rs2), .qry_hit(qry_hit),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_dat(rf_dat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    wb_vld = wv; wb_rd = wr; wb_dat = wd;
    mc_vld = mv; mc_rd = mr; mc_dat = md;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    qry_rs1 = 5'd3;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    check("rst_mc_rdy", mc_rdy, 0);
    check("rst_stall", wb_stall, 0);
    check("rst_qry", qry_hit, 0);
    step();
    check("rst_we", rf_we, 0);
    check("rst_rd", rf_rd, 0);
    check("rst_dat", rf_dat, 0);
    rst = 1'b0;
    qry_rs1 = 5'd0;

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hAAAA_0001);
    check("byp_rdy", mc_rdy, 1);
    check("byp_stall", wb_stall, 0);
    step();
    check("byp_we", rf_we, 1);
    check("byp_rd", rf_rd, 5);
    check("byp_dat", rf_dat, 32'hAAAA_0001);
    idle();
    qry_rs1 = 5'd5;
    step();
    check("byp_empty_we", rf_we, 0);
    check("byp_empty_qry", qry_hit, 0);
    qry_rs1 = 5'd0;

    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 5'd3, 32'h300 + 32'(c < 5 ? c : 4), c == 0, 5'd7, 32'h77);
      check("cont_stall", wb_stall, c == 4);
      step();
      check("cont_we", rf_we, 1);
      check("cont_rd", rf_rd, c == 4 ? 7 : 3);
      check("cont_dat", rf_dat, c == 4 ? 32'h77 : 32'h300 + 32'(c < 5 ? c : 4));
    end
    idle();
    step();
    check("cont_drained", rf_we, 0);

    for (int c = 0; c < 7; c++) begin
      drive(f_wv[c], 5'd3, 32'h3000, f_mv[c], f_mr[c], 32'hA00 + 32'(f_mr[c]));
      check("full_rdy", mc_rdy, f_rdy[c]);
      check("full_stall", wb_stall, f_stall[c]);
      step();
      check("full_we", rf_we, 1);
      check("full_rd", rf_rd, f_er[c]);
      check("full_dat", rf_dat, f_er[c] == 5'd3 ? 32'h3000 : 32'hA00 + 32'(f_er[c]));
    end
    idle();
    step();
    check("full_drained", rf_we, 0);

    drive(1'b1, 5'd3, 32'h3333, 1'b1, 5'd9, 32'h1111);
    step();
    drive(1'b1, 5'd9, 32'h2222, 1'b1, 5'd13, 32'hD);
    check("waw_stall", wb_stall, 0);
    step();
    check("waw_rd", rf_rd, 9);
    check("waw_dat", rf_dat, 32'h2222);
    idle();
    step();
    check("waw_next_rd", rf_rd, 13);
    check("waw_next_dat", rf_dat, 32'hD);
    step();
    check("waw_no_old", rf_we, 0);

    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
    check("x0_mc_rdy", mc_rdy, 1);
    step();
    check("x0_mc_we", rf_we, 0);
    idle();
    step();
    check("x0_mc_buf", rf_we, 0);
    drive(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'h0);
    check("x0_wb_stall", wb_stall, 0);
    step();
    check("x0_wb_we", rf_we, 0);

    drive(1'b1, 5'd3, 32'h3000, 1'b1, 5'd12, 32'hC);
    step();
    drive(1'b1, 5'd3, 32'h3001, 1'b0, 5'd0, 32'h0);
    qry_rs2 = 5'd12;
    #1;
    check("qry_hit_buf", qry_hit, 1);
    qry_rs1 = 5'd0; qry_rs2 = 5'd5;
    #1;
    check("qry_x0_miss", qry_hit, 0);
    qry_rs2 = 5'd12;
    rst = 1'b1;
    #1;
    check("qry_rst", qry_hit, 0);
    check("rst_mid_stall", wb_stall, 0);
    step();
    rst = 1'b0;
    idle();
    check("rst_mid_we", rf_we, 0);
    check("rst_mid_qry", qry_hit, 0);
    step();
    check("rst_mid_dropped", rf_we, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage and a multi-cycle unit (divider) that completes out of order.
- Buffers multi-cycle results and applies a starvation-bounded priority policy.
- Stalls writeback when a buffered result must drain.
- Exposes a register-match query so decode can hold RAW hazards on pending results.

Parameters:
XLEN, 32, data width
DEPTH, 2, multi-cycle result buffer entries (>=1)
MAX_WAIT, 4, cycles a buffered head may be denied before the port is forced to it (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wb_vld  in  1  writeback stage presents a register write
wb_rd  in  5  writeback destination register
wb_dat  in  XLEN  writeback data
wb_stall  out  1  writeback must hold its inputs this cycle (combinational)
mc_vld  in  1  multi-cycle unit result valid
mc_rd  in  5  multi-cycle destination register
mc_dat  in  XLEN  multi-cycle result
mc_rdy  out  1  result accepted this cycle (combinational)
qry_rs1  in  5  decode source register 1
qry_rs2  in  5  decode source register 2
qry_hit  out  1  a queried register has a write pending in the buffer or output stage
rf_we  out  1  register-file write enable (registered)
rf_rd  out  5  register-file write index (registered)
rf_dat  out  XLEN  register-file write data (registered)

Behaviour:
- Clocking: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: rf_we=0, rf_rd=0, rf_dat=0, buffer empty, wait_cnt=0. While rst=1, mc_rdy=0, wb_stall=0 and qry_hit=0.
- Latency: a granted write appears on rf_* the cycle after the grant. rf_we lasts exactly one cycle per write.
- Acceptance: mc_rdy = !full, evaluated before this cycle's dequeue. A full buffer never enqueues, even while draining.
- Acceptance of x0: a result with mc_vld&&mc_rdy&&mc_rd==0 is consumed and discarded.
- Force condition: force = buf_nonempty && (full || wait_cnt >= MAX_WAIT).
- Grant priority:
  (1) force → head entry written, wb_stall = wb_vld.
  (2) else wb_vld → writeback granted.
  (3) else buffer nonempty → head written.
  (4) else mc_vld&&mc_rdy → direct bypass to rf_*, no enqueue.
  (5) else rf_we=0.
- x0 grant: a writeback grant with wb_rd==0 produces rf_we=0 but still counts as granted, so no stall.
- Enqueue: mc results accepted in any case other than (4) are enqueued, nonzero rd only. Enqueue and dequeue in the same cycle are both applied.
- wait_cnt:
  - Cleared when the head dequeues or the buffer is empty.
  - Otherwise increments, saturating at MAX_WAIT, each cycle the head is denied.
- WAW squash: when the writeback grant has wb_rd!=0, every buffered entry with the same rd is invalidated (the writeback instruction is younger). An mc result accepted that cycle with the same rd is discarded.
- Squash compaction: squashed entries are removed in order, with no bubbles. Count decreases accordingly.
- Squash at head: if the squash empties the head, wait_cnt clears.
- qry_hit: set when qry_rsN!=0 and it matches any valid buffered rd, or rf_rd while rf_we=1.
- Buffer ordering: the buffer is FIFO among multi-cycle results; results never reorder.
- Simultaneous force with wb_vld=0: the head is written and wb_stall=0.
- Reset mid-operation: all buffered results are dropped and no write is issued the following cycle.

Decomposition:
- Shared types package:
  - REG_W=5 and XLEN.
  - rf_wr_t {logic [REG_W-1:0] rd; logic [XLEN-1:0] dat}, used for wb, mc and rf bundles.
  - grant-source enum {GNT_NONE, GNT_WB, GNT_BUF, GNT_BYP}.
- Sub-module rf_wr_fifo:
  - DEPTH-entry FIFO with per-entry valid bits.
  - squash-by-rd input and in-order compaction.
  - two rd-match query ports.
- Top-level content: rf_wr_arbiter holds the priority/force logic, wait_cnt and the rf_* output register.

Test Plan:
- Bypass: mc_vld=1, mc_rd=5, mc_dat=0xAAAA_0001, wb_vld=0, buffer empty → next cycle rf_we=1, rf_rd=5, rf_dat=0xAAAA_0001. Buffer stays empty.
- Contention: wb_vld held 1 with rd=3 every cycle; mc result rd=7 arrives at cycle 0, MAX_WAIT=4 → cycles 0–3 wb granted. Cycle 4 wb_stall=1 and rd=7 is written at cycle 5. Writeback resumes at cycle 5.
- Full: DEPTH=2 buffer filled while wb_vld=1 → mc_rdy=0, wb_stall=1 until one entry drains. No result is lost. Writes leave in arrival order.
- WAW squash: buffered rd=9 (0x1111), then writeback rd=9 (0x2222) granted → only 0x2222 is ever written to x9. Buffer count drops by one.
- x0 handling: mc_rd=0 accepted with mc_rdy=1 → no write, buffer unchanged. wb_rd=0 → rf_we=0, wb_stall=0.
- Query/reset: buffered rd=12 → qry_rs2=12 gives qry_hit=1, and qry_rs1=0 does not hit. Asserting rst for one cycle → buffer empty, rf_we=0 and qry_hit=0 on the following cycle.
